// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction cache: boolean levels and refill FSM states.
package icache_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// One asynchronous read port, one synchronous write port; only valid bits are reset.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned SETS       = 64,
  parameter  int unsigned TAG_W      = 22,
  localparam int unsigned IDX_W      = $clog2(SETS),
  localparam int unsigned WSEL_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WSEL_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WSEL_W-1:0] wr_word,
  input  logic              wr_data_en,
  input  logic [31:0]       wr_data,
  input  logic              wr_line_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              inv_en
);

  logic [31:0]      data_mem [SETS][LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [SETS-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (wr_data_en) data_mem[wr_idx][wr_word] <= wr_data;
    if (wr_line_en) tag_mem[wr_idx] <= wr_tag;
  end

  // Invalidate (refill start) and line completion never coincide on one index.
  always_ff @(posedge clk) begin
    if (rst)             valid_q         <= '0;
    else if (inv_en)     valid_q[wr_idx] <= FALSE;
    else if (wr_line_en) valid_q[wr_idx] <= TRUE;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_word];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache front end: single-cycle hits, word-by-word
// line refill over the memory controller's req/flag handshake, mispredict abort.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_flag,
  input  logic        fe_req,
  input  logic [31:0] fe_addr,
  output logic        fe_flag,
  output logic [31:0] fe_inst,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_flag,
  input  logic [31:0] mc_inst
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [WSEL_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]  base_tag_q, base_tag_d;
  logic [IDX_W-1:0]  base_idx_q, base_idx_d;
  logic              fe_flag_d;
  logic [31:0]       fe_inst_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_word;
  logic              lookup, hit, miss, last_word, accept;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_data_en, wr_line_en, inv_en;
  logic              unused_addr_lsbs;

  assign req_tag  = fe_addr[31 -: TAG_W];
  assign req_idx  = fe_addr[OFF_W +: IDX_W];
  assign req_word = fe_addr[2 +: WSEL_W];
  assign unused_addr_lsbs = ^fe_addr[1:0];

  // A lookup is skipped while the previous hit pulse is out.
  assign lookup    = (state_q == IDLE) && rdy && fe_req && !fe_flag;
  assign hit       = lookup && rd_valid && (rd_tag == req_tag);
  assign miss      = lookup && !hit;
  assign last_word = (cnt_q == LAST_WORD);
  assign accept    = !rst && !jump_wrong_flag;

  icache_array #(
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (req_idx),
    .rd_word    (req_word),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_idx     (wr_idx),
    .wr_word    (cnt_q),
    .wr_data_en (wr_data_en),
    .wr_data    (mc_inst),
    .wr_line_en (wr_line_en),
    .wr_tag     (base_tag_q),
    .inv_en     (inv_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_tag_q <= '0;
      base_idx_q <= '0;
      fe_flag    <= FALSE;
      fe_inst    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_tag_q <= base_tag_d;
      base_idx_q <= base_idx_d;
      fe_flag    <= fe_flag_d;
      fe_inst    <= fe_inst_d;
    end
  end

  // mc_flag is honoured even while rdy is low: that word was already transferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_tag_d = base_tag_q;
    base_idx_d = base_idx_q;
    fe_flag_d  = FALSE;
    fe_inst_d  = fe_inst;
    if (jump_wrong_flag) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            fe_flag_d = TRUE;
            fe_inst_d = rd_data;
          end else if (miss) begin
            base_tag_d = req_tag;
            base_idx_d = req_idx;
            cnt_d      = '0;
            state_d    = REFILL;
          end
        end
        REFILL: begin
          if (mc_flag) begin
            cnt_d = cnt_q + WSEL_W'(1);
            if (last_word) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mc_req     = (state_q == REFILL);
    mc_addr    = {base_tag_q, base_idx_q, cnt_q, 2'b00};
    wr_idx     = req_idx;
    wr_data_en = FALSE;
    wr_line_en = FALSE;
    inv_en     = FALSE;
    if (state_q == REFILL) begin
      wr_idx     = base_idx_q;
      wr_data_en = mc_flag && accept;
      wr_line_en = mc_flag && accept && last_word;
    end else begin
      inv_en = miss && accept;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: memory-controller responder plus a line-level cache model.
module tb_icache_ctrl;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned SETS       = 64;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W      = $clog2(SETS);

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong_flag, fe_req;
  logic [31:0] fe_addr;
  logic        fe_flag;
  logic [31:0] fe_inst;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_flag;
  logic [31:0] mc_inst;

  int checks = 0;
  int failures = 0;

  bit          mem_en;
  int unsigned mem_lat;
  logic [31:0] served [$];

  bit          mvalid [SETS];
  logic [31:0] mtag   [SETS];

  icache_ctrl #(
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .jump_wrong_flag (jump_wrong_flag),
    .fe_req          (fe_req),
    .fe_addr         (fe_addr),
    .fe_flag         (fe_flag),
    .fe_inst         (fe_inst),
    .mc_req          (mc_req),
    .mc_addr         (mc_addr),
    .mc_flag         (mc_flag),
    .mc_inst         (mc_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h10) return 32'h11 * (32'(w[3:2]) + 32'd1);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_fill(input logic [31:0] a);
    mvalid[(a >> OFF_W) % SETS] = 1'b1;
    mtag[(a >> OFF_W) % SETS]   = a >> (OFF_W + IDX_W);
  endtask

  // Memory controller: one word per request, mc_flag lasts one cycle, idle in the done cycle.
  initial begin
    int unsigned wait_cnt;
    wait_cnt = 0;
    mc_flag  = 1'b0;
    mc_inst  = '0;
    forever begin
      @(negedge clk);
      if (mc_flag) begin
        mc_flag  = 1'b0;
        mc_inst  = $urandom;
        wait_cnt = mem_lat;
      end else if (mem_en && mc_req === 1'b1) begin
        if (wait_cnt == 0) begin
          mc_flag = 1'b1;
          mc_inst = mem_word(mc_addr);
          served.push_back(mc_addr);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    int unsigned idx;
    logic [31:0] tg, base, exp_inst;
    bit          miss, gap;
    int          cyc, consumed;
    idx      = (a >> OFF_W) % SETS;
    tg       = a >> (OFF_W + IDX_W);
    base     = a & ~(32'(LINE_WORDS * 4) - 32'd1);
    exp_inst = mem_word(a);
    miss     = !(mvalid[idx] && mtag[idx] == tg);
    served.delete();
    cyc = 0;
    gap = 1'b0;
    fe_addr = a;
    fe_req  = 1'b1;
    do begin
      tick();
      cyc++;
      consumed = served.size() - (mc_flag ? 1 : 0);
      if (miss && !fe_flag && consumed < int'(LINE_WORDS) && mc_req !== 1'b1) gap = 1'b1;
    end while (!fe_flag && cyc < 400);
    chk("fetch_fe_flag", 32'(fe_flag), 32'd1);
    chk("fetch_fe_inst", fe_inst, exp_inst);
    chk("fetch_mc_req_idle", 32'(mc_req), 32'd0);
    if (miss) begin
      chk("refill_words", served.size(), LINE_WORDS);
      for (int i = 0; i < served.size(); i++)
        chk("refill_mc_addr", served[i], base + 32'(4 * i));
      chk("refill_req_gap", 32'(gap), 32'd0);
      model_fill(a);
    end else begin
      chk("hit_latency", cyc, 1);
      chk("hit_no_mc", served.size(), 0);
    end
    fe_req = 1'b0;
    tick();
    chk("fe_flag_one_pulse", 32'(fe_flag), 32'd0);
    chk("fe_inst_hold", fe_inst, exp_inst);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] a;
    rst = 1'b1; rdy = 1'b1; jump_wrong_flag = 1'b0;
    fe_req = 1'b0; fe_addr = '0;
    mem_en = 1'b1; mem_lat = 1;
    for (int i = 0; i < int'(SETS); i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
    repeat (3) tick();
    chk("rst_fe_flag", 32'(fe_flag), 32'd0);
    chk("rst_fe_inst", fe_inst, 32'd0);
    chk("rst_mc_req", 32'(mc_req), 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    rst = 1'b0;

    fetch(32'h0);
    fetch(32'h8);
    fetch(32'h400);
    fetch(32'h0);

    // Mispredict abort after two words of the 0x400 line.
    served.delete();
    fe_addr = 32'h400; fe_req = 1'b1; mem_lat = 1; cyc = 0;
    while (!(served.size() == 2 && !mc_flag) && cyc < 200) begin tick(); cyc++; end
    chk("jump_setup", served.size(), 2);
    jump_wrong_flag = 1'b1; fe_req = 1'b0;
    tick();
    jump_wrong_flag = 1'b0;
    chk("jump_mc_req", 32'(mc_req), 32'd0);
    chk("jump_fe_flag", 32'(fe_flag), 32'd0);
    mvalid[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("jump_idle_fe_flag", 32'(fe_flag), 32'd0);
      chk("jump_idle_mc_req", 32'(mc_req), 32'd0);
    end
    fetch(32'h0);

    // Pause coinciding with the second word's done pulse.
    served.delete();
    fe_addr = 32'h1230; fe_req = 1'b1; mem_lat = 1; cyc = 0;
    while (!(served.size() == 2 && mc_flag) && cyc < 200) begin tick(); cyc++; end
    chk("pause_setup", served.size(), 2);
    rdy = 1'b0; mem_en = 1'b0;
    tick();
    chk("pause_mc_addr", mc_addr, 32'h1238);
    chk("pause_mc_req", 32'(mc_req), 32'd1);
    repeat (3) begin
      tick();
      chk("pause_fe_flag", 32'(fe_flag), 32'd0);
      chk("pause_mc_addr_hold", mc_addr, 32'h1238);
    end
    rdy = 1'b1; mem_en = 1'b1; cyc = 0;
    while (!fe_flag && cyc < 200) begin tick(); cyc++; end
    chk("resume_fe_flag", 32'(fe_flag), 32'd1);
    chk("resume_fe_inst", fe_inst, mem_word(32'h1230));
    chk("resume_words", served.size(), 4);
    for (int i = 0; i < served.size(); i++)
      chk("resume_mc_addr", served[i], 32'h1230 + 32'(4 * i));
    fe_req = 1'b0;
    tick();
    model_fill(32'h1230);

    // Random fetches over a small tag/index pool to force hits and conflicts.
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
        | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      mem_lat = $urandom_range(0, 3);
      fetch(a);
    end

    // Reset in the middle of a refill invalidates every line.
    mem_lat = 1;
    fetch(32'h8);
    served.delete();
    fe_addr = 32'h2000; fe_req = 1'b1; cyc = 0;
    while (!(served.size() == 2 && !mc_flag) && cyc < 200) begin tick(); cyc++; end
    chk("rst_mid_setup", served.size(), 2);
    rst = 1'b1; fe_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_mc_req", 32'(mc_req), 32'd0);
    chk("rst_mid_mc_addr", mc_addr, 32'd0);
    chk("rst_mid_fe_inst", fe_inst, 32'd0);
    for (int i = 0; i < int'(SETS); i++) mvalid[i] = 1'b0;
    fetch(32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
